// File: rtl/alu_input_sequencer_if.sv
// ALU operand/result handshake bundle between the input sequencer and the ALU.
// The sequencer owns operands, opcode and valid; the ALU side returns ready and result.
interface alu_input_sequencer_if;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  aluop;
  logic        valid;
  logic        ready;
  logic [31:0] result;

  modport master (
    output port_a,
    output port_b,
    output aluop,
    output valid,
    input  ready,
    input  result
  );

  modport slave (
    input  port_a,
    input  port_b,
    input  aluop,
    input  valid,
    output ready,
    output result
  );
endinterface

// File: rtl/alu_input_sequencer.sv
// Key/switch driven operand sequencer for the ALU board wrapper.
// Keys are inverted, double-flop synchronised and (optionally) debounced; KEY[0] is enter,
// KEY[1] is abort. Operands and opcode are loaded from the switches in turn, issued with a
// valid/ready handshake, and the captured result is shown on disp_word.
// Optional feature: define ALU_SEQ_DEBOUNCE_EN to enable per-key debounce counters
// (DEBOUNCE_CYCLES); without it the debounced level is the synchronised level.
module alu_input_sequencer #(
`ifdef ALU_SEQ_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
`endif
  parameter int unsigned SW_W = 18
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [3:0]            KEY,
  input  logic [SW_W-1:0]       SW,
  alu_input_sequencer_if.master alu,
  output logic [31:0]           disp_word,
  output logic [2:0]            stage,
  output logic [3:0]            key_evt
);

  localparam int unsigned DataW = SW_W - 1;

  typedef enum logic [2:0] {
    StLoadA,
    StLoadB,
    StLoadOp,
    StIssue,
    StHold
  } state_e;

  state_e            state_q;
  logic [3:0]        sync1_q, sync2_q, deb_q;
  logic [SW_W-1:0]   sw_q;
  logic [DataW-1:0]  sw_data;
  logic [31:0]       sw_ext;
  logic              enter, abort;

  // Input sampling: invert keys to pressed=1, two-flop synchronise; register switches once.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
    end else begin
      sync1_q <= ~KEY;
      sync2_q <= sync1_q;
      sw_q    <= SW;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CntW-1:0] cnt_q [4];

  // Debounce: accept a new level only after it differs from the debounced one for
  // DEBOUNCE_CYCLES consecutive edges; emit a pulse on an accepted press.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      deb_q   <= '0;
      key_evt <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      key_evt <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]   <= sync2_q[i];
          cnt_q[i]   <= '0;
          key_evt[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end
`else
  // No debounce: track the synchronised level and pulse on each rising edge.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      deb_q   <= '0;
      key_evt <= '0;
    end else begin
      deb_q   <= sync2_q;
      key_evt <= sync2_q & ~deb_q;
    end
  end
`endif

  assign enter = key_evt[0];
  assign abort = key_evt[1];

  // Switch operand: top switch selects sign- versus zero-extension of the data bits.
  always_comb begin
    sw_data = sw_q[DataW-1:0];
    if (sw_q[SW_W-1]) begin
      sw_ext = {{(32 - DataW){sw_data[DataW-1]}}, sw_data};
    end else begin
      sw_ext = {{(32 - DataW){1'b0}}, sw_data};
    end
  end

  // Sequencer FSM with registered operand, handshake and display outputs; abort beats enter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StLoadA;
      alu.port_a <= '0;
      alu.port_b <= '0;
      alu.aluop  <= '0;
      alu.valid  <= 1'b0;
      disp_word  <= '0;
      stage      <= 3'b001;
    end else if (abort) begin
      state_q   <= StLoadA;
      alu.valid <= 1'b0;
      stage     <= 3'b001;
    end else begin
      unique case (state_q)
        StLoadA: begin
          disp_word <= sw_ext;
          if (enter) begin
            alu.port_a <= sw_ext;
            state_q    <= StLoadB;
            stage      <= 3'b010;
          end
        end
        StLoadB: begin
          disp_word <= sw_ext;
          if (enter) begin
            alu.port_b <= sw_ext;
            state_q    <= StLoadOp;
            stage      <= 3'b100;
          end
        end
        StLoadOp: begin
          disp_word <= {28'b0, sw_q[3:0]};
          if (enter) begin
            alu.aluop <= sw_q[3:0];
            alu.valid <= 1'b1;
            state_q   <= StIssue;
            stage     <= 3'b000;
          end
        end
        StIssue: begin
          if (alu.ready) begin
            disp_word <= alu.result;
            alu.valid <= 1'b0;
            state_q   <= StHold;
          end
        end
        StHold: begin
          if (enter) begin
            state_q <= StLoadA;
            stage   <= 3'b001;
          end
        end
        default: begin
          state_q   <= StLoadA;
          alu.valid <= 1'b0;
          stage     <= 3'b001;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: table-driven operand/issue vectors with a result
// scoreboard, plus hand sequences for reset, key latency/bounce, abort and mid-issue reset.
module tb_alu_input_sequencer;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int KeyLat = 2 + 4;
`else
  localparam int KeyLat = 3;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [31:0] disp_word;
  logic [2:0]  stage;
  logic [3:0]  key_evt;

  alu_input_sequencer_if alu_if ();

  alu_input_sequencer #(
`ifdef ALU_SEQ_DEBOUNCE_EN
    .DEBOUNCE_CYCLES(4),
`endif
    .SW_W(18)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .KEY      (KEY),
    .SW       (SW),
    .alu      (alu_if),
    .disp_word(disp_word),
    .stage    (stage),
    .key_evt  (key_evt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of issued transactions; popped when the handshake is seen.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
  } txn_t;

  txn_t        sb_q[$];
  logic        pend = 1'b0;
  logic [31:0] pend_val = '0;

  always @(negedge CLK) begin
    txn_t t;
    if (pend) begin
      check("sb_disp", disp_word, pend_val);
      pend <= 1'b0;
    end
    if (nRST && alu_if.valid && alu_if.ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: handshake with empty scoreboard, port_a %h", alu_if.port_a);
      end else begin
        t = sb_q.pop_front();
        check("sb_port_a", alu_if.port_a, t.a);
        check("sb_port_b", alu_if.port_b, t.b);
        check("sb_aluop", {28'b0, alu_if.aluop}, {28'b0, t.op});
        pend     <= 1'b1;
        pend_val <= t.res;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Press the given keys and return once the FSM has consumed the resulting event.
  task automatic press(input logic [3:0] keys, output logic [3:0] evt_seen);
    KEY = ~keys;
    evt_seen = '0;
    for (int c = 0; c < 64; c++) begin
      tick(1);
      if (key_evt != 4'b0) begin
        evt_seen = key_evt;
        break;
      end
    end
    if (evt_seen == 4'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL press_timeout: got no key_evt required %b", keys);
    end
    tick(1);
    KEY = 4'hF;
  endtask

  task automatic settle();
    tick(KeyLat + 3);
  endtask

  typedef struct {
    logic [17:0] sw_a;
    logic [17:0] sw_b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          delay;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [3:0]  e;
    logic [3:0]  last_op;
    logic [31:0] last_a;
    int          pulses;
    int          lat;

    vecs[0] = '{18'h00005, 18'h00003, 4'h2, 32'h00000008, 32'h00000005, 32'h00000003, 0};
    vecs[1] = '{18'h3FFFF, 18'h1FFFF, 4'hA, 32'h12345678, 32'hFFFFFFFF, 32'h0001FFFF, 0};
    vecs[2] = '{18'h20001, 18'h10000, 4'hF, 32'hDEADBEEF, 32'h00000001, 32'h00010000, 10};
    vecs[3] = '{18'h30000, 18'h0FFFF, 4'h0, 32'hCAFEF00D, 32'hFFFF0000, 32'h0000FFFF, 3};

    KEY = 4'hF;
    SW = '0;
    alu_if.ready = 1'b0;
    alu_if.result = '0;
    nRST = 1'b0;
    tick(2);
    check("rst_stage", {29'b0, stage}, 32'h1);
    check("rst_valid", {31'b0, alu_if.valid}, 32'h0);
    check("rst_port_a", alu_if.port_a, 32'h0);
    check("rst_port_b", alu_if.port_b, 32'h0);
    check("rst_aluop", {28'b0, alu_if.aluop}, 32'h0);
    check("rst_disp", disp_word, 32'h0);
    check("rst_key_evt", {28'b0, key_evt}, 32'h0);
    nRST = 1'b1;
    tick(2);

    for (int i = 0; i < 4; i++) begin
      SW = vecs[i].sw_a;
      tick(3);
      check("vec_disp_a", disp_word, vecs[i].exp_a);
      press(4'b0001, e);
      check("vec_stage_b", {29'b0, stage}, 32'h2);
      check("vec_port_a", alu_if.port_a, vecs[i].exp_a);
      settle();

      SW = vecs[i].sw_b;
      tick(3);
      check("vec_disp_b", disp_word, vecs[i].exp_b);
      press(4'b0001, e);
      check("vec_stage_op", {29'b0, stage}, 32'h4);
      check("vec_port_b", alu_if.port_b, vecs[i].exp_b);
      settle();

      SW = {14'h1B3C, vecs[i].op};
      tick(3);
      check("vec_disp_op", disp_word, {28'b0, vecs[i].op});
      if (vecs[i].delay == 0) begin
        alu_if.ready = 1'b1;
        alu_if.result = vecs[i].res;
        sb_q.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].op, vecs[i].res});
      end
      press(4'b0001, e);
      check("vec_valid_rise", {31'b0, alu_if.valid}, 32'h1);
      check("vec_stage_issue", {29'b0, stage}, 32'h0);
      check("vec_aluop", {28'b0, alu_if.aluop}, {28'b0, vecs[i].op});
      for (int d = 0; d < vecs[i].delay; d++) begin
        alu_if.result = $urandom;
        tick(1);
        check("hold_valid", {31'b0, alu_if.valid}, 32'h1);
        check("hold_port_a", alu_if.port_a, vecs[i].exp_a);
        check("hold_port_b", alu_if.port_b, vecs[i].exp_b);
      end
      if (vecs[i].delay != 0) begin
        sb_q.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].op, vecs[i].res});
        alu_if.ready = 1'b1;
        alu_if.result = vecs[i].res;
      end
      tick(1);
      check("vec_valid_fall", {31'b0, alu_if.valid}, 32'h0);
      check("vec_disp_res", disp_word, vecs[i].res);
      check("vec_stage_hold", {29'b0, stage}, 32'h0);
      // ready without valid must not recapture
      alu_if.result = ~vecs[i].res;
      tick(2);
      check("hold_no_capture", disp_word, vecs[i].res);
      alu_if.ready = 1'b0;
      settle();
      press(4'b0001, e);
      check("vec_back_to_a", {29'b0, stage}, 32'h1);
      settle();
    end
    last_op = vecs[3].op;

    // Key latency; with debounce the press is preceded by bouncing that must be rejected.
    SW = 18'h00042;
    tick(3);
    pulses = 0;
    lat = -1;
`ifdef ALU_SEQ_DEBOUNCE_EN
    for (int i = 0; i < 20; i++) begin
      KEY[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      if (key_evt[0]) pulses++;
    end
`endif
    KEY[0] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (key_evt[0]) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
    check("key_pulse_count", pulses, 1);
    check("key_latency", lat, KeyLat);
    check("key_stage_once", {29'b0, stage}, 32'h2);
    check("key_port_a", alu_if.port_a, 32'h00000042);
    KEY = 4'hF;
    settle();
    last_a = 32'h00000042;

    // Abort and enter in the same cycle: abort wins.
    SW = 18'h00011;
    press(4'b0001, e);
    settle();
    check("abort_pre_stage", {29'b0, stage}, 32'h4);
    SW = 18'h00009;
    tick(3);
    press(4'b0011, e);
    check("abort_same_cycle", {28'b0, e}, 32'h3);
    check("abort_stage", {29'b0, stage}, 32'h1);
    check("abort_aluop", {28'b0, alu_if.aluop}, {28'b0, last_op});
    check("abort_valid", {31'b0, alu_if.valid}, 32'h0);
    check("abort_port_a", alu_if.port_a, last_a);
    settle();

    // Reset while an operation is waiting for ready.
    SW = 18'h00077;
    for (int k = 0; k < 3; k++) begin
      press(4'b0001, e);
      settle();
    end
    check("mid_valid_pre", {31'b0, alu_if.valid}, 32'h1);
    nRST = 1'b0;
    tick(1);
    check("mid_valid_rst", {31'b0, alu_if.valid}, 32'h0);
    check("mid_stage_rst", {29'b0, stage}, 32'h1);
    check("mid_disp_rst", disp_word, 32'h0);
    check("mid_port_a_rst", alu_if.port_a, 32'h0);
    nRST = 1'b1;
    alu_if.ready = 1'b1;
    alu_if.result = 32'h55AA55AA;
    tick(4);
    check("mid_no_capture", disp_word, 32'h00000077);
    check("mid_valid_after", {31'b0, alu_if.valid}, 32'h0);
    alu_if.ready = 1'b0;

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
